// File: rtl/game_counter_pkg.sv
// Shared types for the game counter: host control modes, FSM states and the
// game-over "who" encoding.
package game_counter_pkg;

  typedef enum logic [1:0] {
    UP_SMALL = 2'b00,
    UP_LARGE = 2'b01,
    DN_SMALL = 2'b10,
    DN_LARGE = 2'b11
  } ctrl_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10
  } who_e;

endpackage

// File: rtl/game_counter_mc_score_tracker.sv
// One side's score register. Clears on clr, increments on inc, and flags hit
// combinationally on the edge where the score is about to reach SCORE_LIMIT.
module score_tracker #(
  parameter int SCORE_W     = 4,
  parameter int SCORE_LIMIT = 15
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] score,
  output logic               hit
);

  localparam logic [SCORE_W-1:0] LIMIT_V = SCORE_W'(SCORE_LIMIT);

  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic [SCORE_W-1:0] score_inc;

  assign score_inc = score_q + 1'b1;

  always_comb begin
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (inc) begin
      score_d = score_inc;
    end
  end

  // Combinational so the FSM can move to OVER on the same edge as the increment.
  assign hit = inc && !clr && (score_inc == LIMIT_V);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/game_counter_mc.sv
// Multi-mode up/down game counter with per-side scores and acknowledged game over.
// Define GAME_COUNTER_SAT_EN to make the counter saturate instead of wrapping.
module game_counter_mc
  import game_counter_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SCORE_W     = 4,
  parameter int SCORE_LIMIT = 15,
  parameter int STEP_SMALL  = 1,
  parameter int STEP_LARGE  = 2
) (
  input  logic               clk,
  input  logic               rst_l,
  input  logic [1:0]         ctrl,
  input  logic               en,
  input  logic               init,
  input  logic [CNT_W-1:0]   load_value,
  input  logic               ack,
  output logic [CNT_W-1:0]   count,
  output logic               loser,
  output logic               winner,
  output logic [SCORE_W-1:0] loser_score,
  output logic [SCORE_W-1:0] winner_score,
  output logic [1:0]         who,
  output logic               gameover
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STEP_S  = CNT_W'(STEP_SMALL);
  localparam logic [CNT_W-1:0] STEP_L  = CNT_W'(STEP_LARGE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             loser_q, loser_d;
  logic             winner_q, winner_d;
  who_e             who_q, who_d;
  logic             gameover_q, gameover_d;

  logic             loser_inc, winner_inc;
  logic             loser_hit, winner_hit;
  logic [CNT_W-1:0] step;
  logic             down;
  logic [CNT_W-1:0] count_step;

  always_comb begin
    step = STEP_S;
    down = 1'b0;
    case (ctrl_mode_e'(ctrl))
      UP_SMALL: begin step = STEP_S; down = 1'b0; end
      UP_LARGE: begin step = STEP_L; down = 1'b0; end
      DN_SMALL: begin step = STEP_S; down = 1'b1; end
      DN_LARGE: begin step = STEP_L; down = 1'b1; end
      default:  begin step = STEP_S; down = 1'b0; end
    endcase
`ifdef GAME_COUNTER_SAT_EN
    if (down) begin
      count_step = (count_q < step) ? '0 : count_q - step;
    end else begin
      count_step = (step > (CNT_MAX - count_q)) ? CNT_MAX : count_q + step;
    end
`else
    count_step = down ? count_q - step : count_q + step;
`endif
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    loser_d    = 1'b0;
    winner_d   = 1'b0;
    who_d      = who_q;
    gameover_d = gameover_q;
    loser_inc  = 1'b0;
    winner_inc = 1'b0;
    if (init) begin
      state_d    = RUN;
      count_d    = load_value;
      who_d      = WHO_NONE;
      gameover_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            // Detection looks at the count before this edge's update.
            loser_inc  = (count_q == '0);
            winner_inc = !loser_inc && (count_q == CNT_MAX);
            loser_d    = loser_inc;
            winner_d   = winner_inc;
            count_d    = count_step;
            if (loser_hit) begin
              state_d    = OVER;
              gameover_d = 1'b1;
              who_d      = WHO_LOSER;
            end else if (winner_hit) begin
              state_d    = OVER;
              gameover_d = 1'b1;
              who_d      = WHO_WINNER;
            end
          end
        end
        OVER: begin
          if (ack) begin
            state_d    = IDLE;
            gameover_d = 1'b0;
            who_d      = WHO_NONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      count_q    <= '0;
      loser_q    <= 1'b0;
      winner_q   <= 1'b0;
      who_q      <= WHO_NONE;
      gameover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      loser_q    <= loser_d;
      winner_q   <= winner_d;
      who_q      <= who_d;
      gameover_q <= gameover_d;
    end
  end

  score_tracker #(
    .SCORE_W    (SCORE_W),
    .SCORE_LIMIT(SCORE_LIMIT)
  ) u_loser_score (
    .clk  (clk),
    .rst_l(rst_l),
    .clr  (init),
    .inc  (loser_inc),
    .score(loser_score),
    .hit  (loser_hit)
  );

  score_tracker #(
    .SCORE_W    (SCORE_W),
    .SCORE_LIMIT(SCORE_LIMIT)
  ) u_winner_score (
    .clk  (clk),
    .rst_l(rst_l),
    .clr  (init),
    .inc  (winner_inc),
    .score(winner_score),
    .hit  (winner_hit)
  );

  assign count    = count_q;
  assign loser    = loser_q;
  assign winner   = winner_q;
  assign who      = who_q;
  assign gameover = gameover_q;

endmodule
